// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op encoding, FSM state type and helpers for the multiply/divide unit
//
// Purpose : op codes driven by the EX-stage controller into mdu_unit, the
//           mdu_unit FSM state type, and a classifier for long-latency ops.
// Ports   : none (package).

package mdu_pkg;

    localparam int OP_W  = 4;
    localparam int CNT_W = 4;

    localparam logic [OP_W-1:0] MD_NONE = 4'd0;
    localparam logic [OP_W-1:0] MULT    = 4'd1;
    localparam logic [OP_W-1:0] MULTU   = 4'd2;
    localparam logic [OP_W-1:0] DIV     = 4'd3;
    localparam logic [OP_W-1:0] DIVU    = 4'd4;
    localparam logic [OP_W-1:0] MTHI    = 4'd5;
    localparam logic [OP_W-1:0] MTLO    = 4'd6;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdu_state_e;

    // Ops that occupy the unit for a multi-cycle busy period.
    function automatic logic is_long_op(input logic [OP_W-1:0] op);
        return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// rtl/mdu_calc.sv - combinational 32x32 multiply and divide datapath
//
// Purpose : computes the 64-bit {hi,lo} result for MULT/MULTU/DIV/DIVU.
// Ports   : i_op     - operation code (mdu_pkg encoding)
//           i_a      - rs operand (multiplicand / dividend)
//           i_b      - rt operand (multiplier / divisor)
//           o_result - {hi, lo}; for divides hi=remainder, lo=quotient
//           o_we     - result should be committed (low for divide by zero
//                      and for any op that is not a mult/div)

module mdu_calc
    import mdu_pkg::*;
(
    input  logic [OP_W-1:0] i_op,
    input  logic [31:0]     i_a,
    input  logic [31:0]     i_b,
    output logic [63:0]     o_result,
    output logic            o_we
);

    logic [63:0] w_prod_u;
    logic [63:0] w_prod_s;
    logic        w_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_divisor;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_q;
    logic [31:0] w_r;

    assign w_prod_u = {32'b0, i_a} * {32'b0, i_b};
    assign w_prod_s = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};

    // Signed divide is done on magnitudes and the signs restored afterwards.
    // The magnitude of 0x80000000 is still 0x80000000 as an unsigned value,
    // so 0x80000000 / -1 naturally yields quotient 0x80000000, remainder 0.
    assign w_signed  = (i_op == DIV);
    assign w_a_neg   = w_signed & i_a[31];
    assign w_b_neg   = w_signed & i_b[31];
    assign w_a_mag   = w_a_neg ? (32'd0 - i_a) : i_a;
    assign w_b_mag   = w_b_neg ? (32'd0 - i_b) : i_b;
    // Keep the divider defined on a zero divisor; its result is discarded.
    assign w_divisor = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
    assign w_q_mag   = w_a_mag / w_divisor;
    assign w_r_mag   = w_a_mag % w_divisor;
    assign w_q       = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_r       = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

    always_comb begin
        o_result = 64'd0;
        o_we     = 1'b0;
        case (i_op)
            MULT: begin
                o_result = w_prod_s;
                o_we     = 1'b1;
            end
            MULTU: begin
                o_result = w_prod_u;
                o_we     = 1'b1;
            end
            DIV, DIVU: begin
                o_result = {w_r, w_q};
                o_we     = (i_b != 32'd0);
            end
            default: begin
                o_result = 64'd0;
                o_we     = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// rtl/mdu_unit.sv - multi-cycle multiply/divide unit holding HI/LO
//
// Purpose : accepts mult/div and HI/LO move requests, computes the result at
//           the start edge, holds it pending for a fixed busy period, then
//           commits it to HI/LO.
// Ports   : clk       - system clock, rising edge
//           reset     - asynchronous active-low reset
//           start     - one-cycle request strobe, qualifies op/A/B
//           op        - operation code (mdu_pkg encoding)
//           A, B      - rs / rt operands
//           busy      - a mult/div is in flight
//           stall_req - busy, or a mult/div being requested this cycle
//           HI, LO    - architectural HI/LO registers

module mdu_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
)
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [OP_W-1:0] op,
    input  logic [31:0]     A,
    input  logic [31:0]     B,
    output logic            busy,
    output logic            stall_req,
    output logic [31:0]     HI,
    output logic [31:0]     LO
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    mdu_state_e       r_state;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [63:0]      r_pend;
    logic             r_pend_we;

    mdu_state_e       w_state_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic [31:0]      w_hi_nxt;
    logic [31:0]      w_lo_nxt;
    logic [63:0]      w_pend_nxt;
    logic             w_pend_we_nxt;

    logic [63:0]      w_calc_result;
    logic             w_calc_we;

    mdu_calc u_calc (
        .i_op     (op),
        .i_a      (A),
        .i_b      (B),
        .o_result (w_calc_result),
        .o_we     (w_calc_we)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend    <= 64'd0;
            r_pend_we <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_hi      <= w_hi_nxt;
            r_lo      <= w_lo_nxt;
            r_pend    <= w_pend_nxt;
            r_pend_we <= w_pend_we_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_hi_nxt      = r_hi;
        w_lo_nxt      = r_lo;
        w_pend_nxt    = r_pend;
        w_pend_we_nxt = r_pend_we;

        case (r_state)
            IDLE: begin
                if (start) begin
                    case (op)
                        MULT, MULTU: begin
                            w_pend_nxt    = w_calc_result;
                            w_pend_we_nxt = w_calc_we;
                            w_count_nxt   = MULT_LOAD;
                            w_state_nxt   = RUN;
                        end
                        DIV, DIVU: begin
                            w_pend_nxt    = w_calc_result;
                            w_pend_we_nxt = w_calc_we;
                            w_count_nxt   = DIV_LOAD;
                            w_state_nxt   = RUN;
                        end
                        MTHI:    w_hi_nxt = A;
                        MTLO:    w_lo_nxt = A;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                // Requests arriving while running are dropped, not queued.
                w_count_nxt = r_count - 1'b1;
                // A zero count here cannot occur for legal parameters; it is
                // treated as the final cycle so the FSM can never wedge.
                if (r_count <= 1) begin
                    w_count_nxt = '0;
                    w_state_nxt = IDLE;
                    if (r_pend_we) begin
                        w_hi_nxt = r_pend[63:32];
                        w_lo_nxt = r_pend[31:0];
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_count_nxt = '0;
            end
        endcase
    end

    assign busy      = (r_state == RUN);
    assign stall_req = busy | (start & is_long_op(op));
    assign HI        = r_hi;
    assign LO        = r_lo;

endmodule

// File: tb/tb_mdu_unit.sv
// tb/tb_mdu_unit.sv - self-checking bench for mdu_unit against an arithmetic reference model

module tb_mdu_unit;
    import mdu_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        stall_req;
    logic [31:0] HI;
    logic [31:0] LO;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mdu_unit #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .stall_req (stall_req),
        .HI        (HI),
        .LO        (LO)
    );

    always #5 clk = ~clk;

    // Protocol monitor: a request while busy is a caller error (the unit drops it).
    always @(posedge clk) begin
        if (reset === 1'b1 && busy === 1'b1 && start === 1'b1)
            $display("note: protocol violation, start while busy at %0t (request dropped)", $time);
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running required done");
        $fatal(1, "timeout");
    end

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: architectural effect of one accepted request, from plain arithmetic.
    task automatic model_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                            output int n);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = {32'd0, a};
        longint unsigned ub = {32'd0, b};
        longint          sp;
        n = 0;
        case (o)
            MULT: begin
                n  = MULT_N;
                sp = sa * sb;
                m_hi = sp[63:32];
                m_lo = sp[31:0];
            end
            MULTU: begin
                n = MULT_N;
                {m_hi, m_lo} = ua * ub;
            end
            DIV: begin
                n = DIV_N;
                if (b != 32'd0) begin
                    m_lo = 32'(sa / sb);
                    m_hi = 32'(sa % sb);
                end
            end
            DIVU: begin
                n = DIV_N;
                if (b != 32'd0) begin
                    m_lo = 32'(ua / ub);
                    m_hi = 32'(ua % ub);
                end
            end
            MTHI:    m_hi = a;
            MTLO:    m_lo = a;
            default: ;
        endcase
    endtask

    // Issue one request, measure the busy period, then check the committed HI/LO.
    // inj_at > 0 pulses an MTHI request on that busy cycle; it must be dropped.
    task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int inj_at, input string tag);
        int          n;
        int          cnt;
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        bit          stall_ok;
        bit          hold_ok;
        old_hi = m_hi;
        old_lo = m_lo;
        model_op(o, a, b, n);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        #1;
        check_value({tag, ":stall_start"}, {63'd0, stall_req}, {63'd0, n > 0});
        @(negedge clk);
        start    = 1'b0;
        op       = MD_NONE;
        cnt      = 0;
        stall_ok = 1'b1;
        hold_ok  = 1'b1;
        while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            if (stall_req !== 1'b1) stall_ok = 1'b0;
            if (HI !== old_hi || LO !== old_lo) hold_ok = 1'b0;
            if (cnt == inj_at) begin
                start = 1'b1;
                op    = MTHI;
                A     = 32'h55;
            end
            @(negedge clk);
            start = 1'b0;
            op    = MD_NONE;
        end
        check_value({tag, ":busy_cycles"}, 64'(cnt), 64'(n));
        if (n > 0) begin
            check_value({tag, ":stall_busy"}, {63'd0, stall_ok}, 64'd1);
            check_value({tag, ":hold_old"}, {63'd0, hold_ok}, 64'd1);
        end
        check_value({tag, ":HI"}, {32'd0, HI}, {32'd0, m_hi});
        check_value({tag, ":LO"}, {32'd0, LO}, {32'd0, m_lo});
    endtask

    initial begin
        logic [3:0]  r_o;
        logic [31:0] r_a;
        logic [31:0] r_b;
        bit          late;

        // Reset held with a request pending: nothing may be written.
        reset = 1'b0;
        start = 1'b1;
        op    = MTHI;
        A     = 32'hDEAD_BEEF;
        B     = 32'd0;
        repeat (3) @(negedge clk);
        check_value("reset:HI", {32'd0, HI}, 64'd0);
        check_value("reset:LO", {32'd0, LO}, 64'd0);
        check_value("reset:busy", {63'd0, busy}, 64'd0);
        start = 1'b0;
        op    = MD_NONE;
        reset = 1'b1;

        do_op(MTLO, 32'h1234, 32'd0, -1, "mtlo");
        do_op(MULT, 32'hFFFF_FFFE, 32'd3, -1, "mult");
        check_value("mult:vec", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFA);
        do_op(MULTU, 32'hFFFF_FFFE, 32'd3, -1, "multu");
        check_value("multu:vec", {HI, LO}, 64'h0000_0002_FFFF_FFFA);
        do_op(DIV, 32'hFFFF_FFF9, 32'd2, -1, "div");
        check_value("div:vec", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op(DIVU, 32'd7, 32'd2, -1, "divu");
        check_value("divu:vec", {HI, LO}, 64'h0000_0001_0000_0003);

        do_op(MTHI, 32'hAA, 32'd0, -1, "pre_hi");
        do_op(MTLO, 32'hBB, 32'd0, -1, "pre_lo");
        do_op(DIVU, 32'd1234, 32'd0, -1, "divu_by0");
        check_value("divu_by0:vec", {HI, LO}, 64'h0000_00AA_0000_00BB);
        do_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, "div_ovf");
        check_value("div_ovf:vec", {HI, LO}, 64'h0000_0000_8000_0000);

        do_op(MULT, 32'h0001_0003, 32'hFFFF_0007, 2, "mult_inj");
        do_op(MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, -1, "mult_b2b");
        do_op(4'd9, 32'h1111, 32'h2222, -1, "op_illegal");
        do_op(MD_NONE, 32'h3333, 32'h4444, -1, "op_none");

        for (int i = 0; i < 40; i++) begin
            r_o = 4'($urandom_range(0, 8));
            r_a = $urandom;
            r_b = $urandom;
            case ($urandom_range(0, 5))
                0: r_b = 32'd0;
                1: r_b = 32'hFFFF_FFFF;
                2: r_a = 32'h8000_0000;
                3: r_b = 32'($urandom_range(1, 9));
                default: ;
            endcase
            do_op(r_o, r_a, r_b, -1, "rnd");
        end

        // Abort a divide mid-flight with reset.
        do_op(MTHI, 32'h77, 32'd0, -1, "pre_abort");
        @(negedge clk);
        start = 1'b1;
        op    = DIV;
        A     = 32'd100;
        B     = 32'd7;
        @(negedge clk);
        start = 1'b0;
        op    = MD_NONE;
        repeat (3) @(negedge clk);
        check_value("abort:busy_before", {63'd0, busy}, 64'd1);
        reset = 1'b0;
        #1;
        check_value("abort:busy", {63'd0, busy}, 64'd0);
        check_value("abort:HI", {32'd0, HI}, 64'd0);
        check_value("abort:LO", {32'd0, LO}, 64'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        reset = 1'b1;
        late  = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) late = 1'b1;
        end
        check_value("abort:no_late_commit", {63'd0, late}, 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multi-cycle multiply/divide unit for the EX stage of the pipelined MIPS core.
- Sits beside the single-cycle ALU on the same operand bus A/B.
- Takes mult/div and HI/LO move requests, holds the HI/LO architectural registers, and reports busy to the hazard unit so the pipeline stalls around long operations.
- Single-cycle ALU results flow out combinationally; this block produces its results later, through a start/busy handshake.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..15)

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset: asserted when 0, takes effect immediately, released synchronously to clk upstream.
- start  input  1  one-cycle request strobe; op, A and B are valid in the same cycle.
- op  input  4  MD_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6.
- A  input  32  rs operand.
- B  input  32  rt operand.
- busy  output  1  a mult/div is in flight.
- stall_req  output  1  combinational: busy | (start & op in {MULT,MULTU,DIV,DIVU}).
- HI  output  32  current HI register (MFHI source).
- LO  output  32  current LO register (MFLO source).

Behaviour:
- Reset (reset==0): HI=0, LO=0, busy=0, counter=0, pending result=0. Asserting reset mid-operation aborts the operation; nothing is committed.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, counter down-counting.
- IDLE, start=1, op in MULT/MULTU/DIV/DIVU:
  - At that edge, latch the computed 64-bit result into the pending registers.
  - Load counter = MULT_CYCLES or DIV_CYCLES; go to RUN.
- RUN:
  - Decrement the counter each edge.
  - On the edge where the counter goes 1->0, commit pending {hi,lo} to HI/LO and return to IDLE.
- Latency, with start sampled at edge t:
  - busy=1 during cycles t+1 .. t+N.
  - HI/LO hold the new values and busy=0 from cycle t+N+1.
  - Example: MULT with N=5 gives 5 busy cycles.
- HI/LO stay unchanged while RUN; MFHI/MFLO read the old values. The hazard unit must stall MFHI/MFLO/MTHI/MTLO/mult/div on stall_req.
- start while busy=1: ignored entirely (no relatch, no HI/LO write). A bench assertion flags it as a protocol error.
- MTHI/MTLO, start=1 in IDLE: HI<=A or LO<=A at that edge; busy stays 0; no counter activity.
- op=MD_NONE or op>6 with start=1: no effect.
- Arithmetic:
  - MULT: signed 32x32 -> 64, {HI,LO}=product.
  - MULTU: unsigned 32x32 -> 64, {HI,LO}=product.
  - DIV: signed; LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - DIVU: unsigned; LO=quotient, HI=remainder.
- Divide boundaries:
  - B==0 (DIV or DIVU): full busy period runs, then HI and LO are left unchanged.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
- Back-to-back: start is accepted in the first IDLE cycle after commit, i.e. cycle t+N+1.

Decomposition:
- Shared package mdu_pkg:
  - op encoding constants MD_NONE..MTLO.
  - state enum IDLE/RUN.
  - This package is also imported by the controller that generates op.
- One sub-module, mdu_calc: purely combinational; op, A, B -> 64-bit result plus a write-enable flag (low for div-by-zero). Instantiated once in mdu_unit.
- The counter, FSM and HI/LO registers live in mdu_unit.

Test Plan:
- Reset: hold reset=0 with start=1, op=MTHI -> HI=LO=0, busy=0. Release reset, then MTLO with A=0x1234 -> LO=0x00001234 on the next cycle, busy never asserts.
- MULT A=0xFFFFFFFE (-2), B=3 -> busy high for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV A=0xFFFFFFF9 (-7), B=2 -> 10 busy cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=2 -> LO=3, HI=1.
- Division boundaries:
  - Preload HI=0xAA, LO=0xBB; DIVU B=0 -> 10 busy cycles, then HI=0xAA, LO=0xBB.
  - DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Busy and stall behaviour:
  - During a MULT, pulse start with op=MTHI, A=0x55 -> ignored; final HI/LO equal the product.
  - stall_req=1 on the start cycle and every busy cycle.
  - A second MULT issued at t+6 is accepted.
- Reset mid-operation: start a DIV, assert reset at busy cycle 4 -> busy=0 and HI=LO=0 immediately. After release, no late commit occurs.
